// File: rtl/fifo_arb_pkg.sv
// Shared definitions for the FIFO write-port arbiter.
//   arb_state_t : arbiter FSM states (idle / grant held)
//   id_w()      : width of a requester index for a given requester count
//   bc_w()      : width of a beat counter able to hold 0..max_burst
package fifo_arb_pkg;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_GRANT = 1'b1
    } arb_state_t;

    // A single-requester build still needs a 1-bit index.
    function automatic int id_w(input int num_req);
        return (num_req > 1) ? $clog2(num_req) : 1;
    endfunction

    function automatic int bc_w(input int max_burst);
        return (max_burst > 0) ? $clog2(max_burst + 1) : 1;
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Round-robin winner selection (purely combinational).
//   req         : request vector, one bit per requester
//   last_winner : index of the requester served most recently
//   winner      : first requesting index at or after last_winner+1 (with wrap)
//   any_req     : at least one request bit is set
// The request vector is rotated so that last_winner+1 lands on bit 0, priority
// encoded for the lowest set bit, and the offset is rotated back to an index.
module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    last_winner,
    output logic [ID_W-1:0]    winner,
    output logic               any_req
);

    logic [2*NUM_REQ-1:0] req_dbl;
    logic [NUM_REQ-1:0]   rotated;
    int                   start_idx;
    int                   offset;

    always_comb begin
        // The modulo keeps every derived index below NUM_REQ, including
        // non-power-of-2 requester counts.
        start_idx = (int'(last_winner) + 1) % NUM_REQ;
        req_dbl   = {req, req};
        rotated   = NUM_REQ'(req_dbl >> start_idx);

        offset  = 0;
        any_req = 1'b0;
        // Scanning downward leaves the lowest set bit as the final assignment.
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (rotated[k]) begin
                offset  = k;
                any_req = 1'b1;
            end
        end

        winner = ID_W'((start_idx + offset) % NUM_REQ);
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port between NUM_REQ producers.
//   clk, rst      : clock, synchronous active-high reset
//   req_valid     : per-requester beat valid
//   req_data      : packed beat data, requester i at [i*DATA_W +: DATA_W]
//   req_last      : per-requester last-beat marker
//   req_ready     : per-requester ready, one-hot or zero
//   fifo_full     : FIFO full flag (back-pressure)
//   fifo_wr_en    : FIFO write enable (combinational, same-edge write)
//   fifo_data_in  : FIFO write data, zero when no write
//   grant_active  : a grant is held
//   grant_id      : granted requester index, meaningful while grant_active
// A grant lasts until the packet ends, MAX_BURST beats are moved, or the
// granted producer drops valid. A full FIFO stalls the grant but never ends it.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter  int NUM_REQ   = 4,
    parameter  int DATA_W    = 8,
    parameter  int MAX_BURST = 4,
    localparam int ID_W      = id_w(NUM_REQ),
    localparam int BC_W      = bc_w(MAX_BURST)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    input  logic [NUM_REQ-1:0]        req_last,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic                      fifo_full,
    output logic                      fifo_wr_en,
    output logic [DATA_W-1:0]         fifo_data_in,
    output logic                      grant_active,
    output logic [ID_W-1:0]           grant_id
);

    arb_state_t       state;
    logic [ID_W-1:0]  last_winner;
    logic [ID_W-1:0]  grant_id_r;
    logic [BC_W-1:0]  beat_cnt;
    logic             grant_active_r;

    logic [ID_W-1:0]    pick_id;
    logic               any_req;

    logic               g_valid;
    logic               g_last;
    logic [DATA_W-1:0]  g_data;
    logic [NUM_REQ-1:0] g_onehot;

    logic               can_write;
    logic               beat;
    logic               burst_end;
    logic               release_now;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_rr_pick (
        .req         (req_valid),
        .last_winner (last_winner),
        .winner      (pick_id),
        .any_req     (any_req)
    );

    // Select the granted requester's signals. Comparing against each legal
    // index keeps the mux inside 0..NUM_REQ-1 for any requester count.
    always_comb begin
        g_valid  = 1'b0;
        g_last   = 1'b0;
        g_data   = '0;
        g_onehot = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_id_r == ID_W'(i)) begin
                g_valid     = req_valid[i];
                g_last      = req_last[i];
                g_data      = req_data[i*DATA_W +: DATA_W];
                g_onehot[i] = 1'b1;
            end
        end
    end

    // Reset gates the handshake combinationally so no beat moves on the
    // reset edge even while the registered grant is still up.
    always_comb begin
        can_write    = (state == ARB_GRANT) && !fifo_full && !rst;
        req_ready    = can_write ? g_onehot : '0;
        beat         = can_write && g_valid;
        fifo_wr_en   = beat;
        fifo_data_in = beat ? g_data : '0;
        burst_end    = (beat_cnt == BC_W'(MAX_BURST - 1));
        // A missing valid releases regardless of fifo_full.
        release_now  = !g_valid || (beat && (g_last || burst_end));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= ARB_IDLE;
            last_winner    <= ID_W'(NUM_REQ - 1);
            beat_cnt       <= '0;
            grant_id_r     <= '0;
            grant_active_r <= 1'b0;
        end else begin
            case (state)
                ARB_IDLE: begin
                    if (any_req) begin
                        grant_id_r     <= pick_id;
                        beat_cnt       <= '0;
                        grant_active_r <= 1'b1;
                        state          <= ARB_GRANT;
                    end
                end
                ARB_GRANT: begin
                    if (release_now) begin
                        last_winner    <= grant_id_r;
                        beat_cnt       <= '0;
                        grant_active_r <= 1'b0;
                        state          <= ARB_IDLE;
                    end else if (beat) begin
                        beat_cnt <= beat_cnt + BC_W'(1);
                    end
                end
                default: begin
                    grant_active_r <= 1'b0;
                    state          <= ARB_IDLE;
                end
            endcase
        end
    end

    assign grant_active = grant_active_r;
    assign grant_id     = grant_id_r;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: a 4-requester instance checked every
// cycle against a queue-based behavioural model, plus a 3-requester instance
// for the non-power-of-2 wrap case, with literal write/grant logs per test.
module tb_fifo_wr_arbiter;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int MB = 4;
    localparam int N3 = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst;
    logic [N-1:0]      req_valid;
    logic [N*DW-1:0]   req_data;
    logic [N-1:0]      req_last;
    logic [N-1:0]      req_ready;
    logic              fifo_full;
    logic              fifo_wr_en;
    logic [DW-1:0]     fifo_data_in;
    logic              grant_active;
    logic [1:0]        grant_id;

    logic [N3-1:0]     v3;
    logic [N3*DW-1:0]  d3;
    logic [N3-1:0]     l3;
    logic [N3-1:0]     r3;
    logic              full3;
    logic              wr3;
    logic [DW-1:0]     dout3;
    logic              ga3;
    logic [1:0]        gid3;

    fifo_wr_arbiter #(.NUM_REQ(N), .DATA_W(DW), .MAX_BURST(MB)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_data     (req_data),
        .req_last     (req_last),
        .req_ready    (req_ready),
        .fifo_full    (fifo_full),
        .fifo_wr_en   (fifo_wr_en),
        .fifo_data_in (fifo_data_in),
        .grant_active (grant_active),
        .grant_id     (grant_id)
    );

    fifo_wr_arbiter #(.NUM_REQ(N3), .DATA_W(DW), .MAX_BURST(MB)) dut3 (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (v3),
        .req_data     (d3),
        .req_last     (l3),
        .req_ready    (r3),
        .fifo_full    (full3),
        .fifo_wr_en   (wr3),
        .fifo_data_in (dout3),
        .grant_active (ga3),
        .grant_id     (gid3)
    );

    // Producer queues: bit 8 = last, bits 7:0 = data.
    logic [8:0] q [N][$];
    logic [7:0] wlog [$];
    int         glog [$];
    logic [7:0] wlog3 [$];
    int         glog3 [$];

    logic [N-1:0]  fire;
    logic [N3-1:0] fire3;
    logic          ga_prev, ga3_prev;

    int n_chk  = 0;
    int n_fail = 0;

    // Behavioural model: current owner (-1 = none), beats moved, last served.
    int m_owner = -1;
    int m_last  = N - 1;
    int m_cnt   = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", nm, act, act, exp, exp, $time);
        end
    endtask

    task automatic drive_inputs();
        for (int i = 0; i < N; i++) begin
            if (q[i].size() > 0) begin
                req_valid[i]           = 1'b1;
                req_data[i*DW +: DW]   = q[i][0][7:0];
                req_last[i]            = q[i][0][8];
            end else begin
                req_valid[i]           = 1'b0;
                req_data[i*DW +: DW]   = '0;
                req_last[i]            = 1'b0;
            end
        end
    endtask

    task automatic push(input int i, input logic [7:0] d, input logic l);
        q[i].push_back({l, d});
    endtask

    // Advance one clock: consume beats accepted in the previous cycle, re-drive.
    task automatic step();
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++)
            if (fire[i]) void'(q[i].pop_front());
        v3 = v3 & ~fire3;
        drive_inputs();
    endtask

    task automatic do_reset();
        for (int i = 0; i < N; i++) q[i].delete();
        v3 = '0;
        fifo_full = 1'b0;
        drive_inputs();
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        wlog.delete();
        glog.delete();
        wlog3.delete();
        glog3.delete();
    endtask

    task automatic wait_done(input string nm, input int budget);
        int c;
        bit busy;
        c = 0;
        busy = 1'b1;
        while (busy && c < budget) begin
            busy = grant_active || (v3 != '0);
            for (int i = 0; i < N; i++) if (q[i].size() > 0) busy = 1'b1;
            if (busy) begin
                step();
                c++;
            end
        end
        if (busy) chk({nm, "_timeout"}, c, -1);
        step();
        step();
    endtask

    task automatic chk_wlog(input string nm, input logic [7:0] exp [$]);
        chk({nm, "_wcount"}, wlog.size(), exp.size());
        for (int i = 0; i < exp.size() && i < wlog.size(); i++)
            chk({nm, "_wdata"}, int'(wlog[i]), int'(exp[i]));
    endtask

    task automatic chk_glog(input string nm, input int exp [$]);
        chk({nm, "_gcount"}, glog.size(), exp.size());
        for (int i = 0; i < exp.size() && i < glog.size(); i++)
            chk({nm, "_gid"}, glog[i], exp[i]);
    endtask

    // Per-cycle compare against the model, plus logging of writes and grants.
    always @(negedge clk) begin
        int  e_ready, e_wr, e_data, o, idx;
        bit  rel, found;
        fire  = req_valid & req_ready;
        fire3 = v3 & r3;

        if (fifo_wr_en) wlog.push_back(fifo_data_in);
        if (grant_active && !ga_prev) glog.push_back(int'(grant_id));
        ga_prev = grant_active;
        if (wr3) wlog3.push_back(dout3);
        if (ga3 && !ga3_prev) glog3.push_back(int'(gid3));
        ga3_prev = ga3;
        if (ga3) chk("n3_gid_range", int'(gid3 < 2'd3), 1);

        e_ready = 0;
        e_wr    = 0;
        e_data  = 0;
        if (rst) begin
            m_owner = -1;
            m_last  = N - 1;
            m_cnt   = 0;
        end else begin
            chk("grant_active", int'(grant_active), int'(m_owner >= 0));
            o = m_owner;
            if (o >= 0) begin
                chk("grant_id", int'(grant_id), o);
                rel = 1'b0;
                if (!fifo_full) e_ready = 1 << o;
                if (q[o].size() == 0) begin
                    rel = 1'b1;
                end else if (!fifo_full) begin
                    e_wr   = 1;
                    e_data = int'(q[o][0][7:0]);
                    m_cnt++;
                    if (q[o][0][8] || m_cnt == MB) rel = 1'b1;
                end
                if (rel) begin
                    m_last  = o;
                    m_owner = -1;
                end
            end else begin
                found = 1'b0;
                for (int k = 1; k <= N; k++) begin
                    idx = (m_last + k) % N;
                    if (!found && q[idx].size() > 0) begin
                        found   = 1'b1;
                        m_owner = idx;
                        m_cnt   = 0;
                    end
                end
            end
        end
        chk("req_ready", int'(req_ready), e_ready);
        chk("fifo_wr_en", int'(fifo_wr_en), e_wr);
        chk("fifo_data_in", int'(fifo_data_in), e_data);
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] ew [$];
        int         eg [$];
        int         c;

        rst       = 1'b1;
        fifo_full = 1'b0;
        full3     = 1'b0;
        v3        = '0;
        d3        = '0;
        l3        = '0;
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        fire      = '0;
        fire3     = '0;
        ga_prev   = 1'b0;
        ga3_prev  = 1'b0;

        do_reset();
        chk("reset_grant_active", int'(grant_active), 0);
        chk("reset_grant_id", int'(grant_id), 0);
        chk("reset_wr_en", int'(fifo_wr_en), 0);

        // Test 1: single requester 2, three beats, last on A3.
        push(2, 8'hA1, 1'b0);
        push(2, 8'hA2, 1'b0);
        push(2, 8'hA3, 1'b1);
        drive_inputs();
        step();
        @(negedge clk);
        chk("t1_grant_latency", int'(grant_active), 1);
        chk("t1_grant_id", int'(grant_id), 2);
        wait_done("t1", 50);
        ew = '{8'hA1, 8'hA2, 8'hA3};
        chk_wlog("t1", ew);
        eg = '{2};
        chk_glog("t1", eg);

        // Test 2: all requesters continuously valid, 8 beats each, no last.
        do_reset();
        for (int i = 0; i < N; i++)
            for (int k = 0; k < 8; k++)
                push(i, 8'((i << 4) | k), 1'b0);
        drive_inputs();
        wait_done("t2", 200);
        ew.delete();
        for (int r = 0; r < 2; r++)
            for (int i = 0; i < N; i++)
                for (int k = 0; k < 4; k++)
                    ew.push_back(8'((i << 4) | (r * 4 + k)));
        chk_wlog("t2", ew);
        eg = '{0, 1, 2, 3, 0, 1, 2, 3};
        chk_glog("t2", eg);

        // Test 3: FIFO full for 5 cycles after beat 2 of requester 1.
        do_reset();
        push(1, 8'h11, 1'b0);
        push(1, 8'h12, 1'b0);
        push(1, 8'h13, 1'b0);
        push(1, 8'h14, 1'b0);
        drive_inputs();
        c = 0;
        while (wlog.size() < 2 && c < 20) begin
            step();
            c++;
        end
        if (wlog.size() < 2) chk("t3_reach_beat2_timeout", c, -1);
        fifo_full = 1'b1;
        repeat (5) begin
            @(negedge clk);
            chk("t3_full_wr_en", int'(fifo_wr_en), 0);
            chk("t3_full_ready", int'(req_ready), 0);
            chk("t3_full_gid", int'(grant_id), 1);
            chk("t3_full_active", int'(grant_active), 1);
            step();
        end
        fifo_full = 1'b0;
        wait_done("t3", 50);
        ew = '{8'h11, 8'h12, 8'h13, 8'h14};
        chk_wlog("t3", ew);
        eg = '{1};
        chk_glog("t3", eg);

        // Test 4: requester 3 drops valid after one beat; rotation continues at 0.
        do_reset();
        push(3, 8'h31, 1'b0);
        drive_inputs();
        c = 0;
        while (!grant_active && c < 10) begin
            step();
            c++;
        end
        if (!grant_active) chk("t4_grant3_timeout", c, -1);
        push(0, 8'h01, 1'b1);
        push(1, 8'h11, 1'b1);
        drive_inputs();
        wait_done("t4", 50);
        ew = '{8'h31, 8'h01, 8'h11};
        chk_wlog("t4", ew);
        eg = '{3, 0, 1};
        chk_glog("t4", eg);

        // Test 5: reset pulse mid-burst of requester 2.
        do_reset();
        push(2, 8'h21, 1'b0);
        push(2, 8'h22, 1'b0);
        push(2, 8'h23, 1'b0);
        push(2, 8'h24, 1'b0);
        drive_inputs();
        c = 0;
        while (wlog.size() < 2 && c < 20) begin
            step();
            c++;
        end
        if (wlog.size() < 2) chk("t5_reach_beat2_timeout", c, -1);
        push(0, 8'h05, 1'b1);
        drive_inputs();
        rst = 1'b1;
        @(negedge clk);
        chk("t5_rst_wr_en", int'(fifo_wr_en), 0);
        chk("t5_rst_ready", int'(req_ready), 0);
        step();
        rst = 1'b0;
        wait_done("t5", 50);
        ew = '{8'h21, 8'h22, 8'h05, 8'h23, 8'h24};
        chk_wlog("t5", ew);
        eg = '{2, 0, 2};
        chk_glog("t5", eg);

        // Test 6: 3-requester build, requesters 0 and 2 valid after reset.
        do_reset();
        d3 = {8'hC2, 8'hC1, 8'hC0};
        l3 = 3'b111;
        v3 = 3'b101;
        wait_done("t6", 30);
        chk("t6_gcount", glog3.size(), 2);
        if (glog3.size() == 2) begin
            chk("t6_gid_first", glog3[0], 0);
            chk("t6_gid_second", glog3[1], 2);
        end
        chk("t6_wcount", wlog3.size(), 2);
        if (wlog3.size() == 2) begin
            chk("t6_wdata_first", int'(wlog3[0]), 8'hC0);
            chk("t6_wdata_second", int'(wlog3[1]), 8'hC2);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
